// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding one shared UART transmitter with bounded bursts per grant.
// Optional watchdog on the transmitter handshake is enabled with `define UART_ARB_WDOG_EN.
//   state     | meaning
//   IDLE      | no owner; waiting for a request while the transmitter is idle
//   START     | byte latched; o_start pulses on the way out of this state
//   WAIT_BUSY | waiting for the transmitter to leave idle
//   WAIT_DONE | waiting for the transmitter to return to idle
module uart_tx_arbiter #(
  parameter int NREQ            = 4,
  parameter int MAX_BURST       = 4,
  parameter int TIMER_BITS      = 32,
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_data,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_start,
  output logic [9:0]        o_frame,
  input  logic [3:0]        i_tx_bit,
  output logic              o_busy,
  output logic [2:0]        o_state,
  output logic              o_fault
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3
  } state_t;

  localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]    BURST_MAX = 4'(MAX_BURST);
  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 15 ||
      TIMER_BITS < 1 || CLOCKS_PER_BAUD < 1) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  state_t          state, state_nxt;
  logic [IW-1:0]   last, last_nxt, owner, owner_nxt, win_idx;
  logic            win_found;
  logic [3:0]      burst, burst_nxt;
  logic [9:0]      frame, frame_nxt;
  logic [NREQ-1:0] ack_nxt, grant_nxt;
  logic            start_nxt;
  logic            tx_idle;
  logic [7:0]      req_byte [NREQ];

  assign tx_idle = (i_tx_bit == 4'hF);

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_byte[g] = i_data[8*g +: 8];
  end

`ifdef UART_ARB_WDOG_EN
  localparam logic [TIMER_BITS-1:0] WDOG_LAST = TIMER_BITS'(12 * CLOCKS_PER_BAUD - 1);
  logic [TIMER_BITS-1:0] wdog, wdog_nxt;
  logic                  fault, fault_nxt;
`endif

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
    burst_nxt = burst;
    frame_nxt = frame;
    ack_nxt   = '0;
    grant_nxt = o_grant;
    start_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found && tx_idle) begin
          owner_nxt          = win_idx;
          frame_nxt          = {1'b1, req_byte[win_idx], 1'b0};
          ack_nxt[win_idx]   = 1'b1;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          burst_nxt          = 4'd1;
          state_nxt          = S_START;
        end
      end
      S_START: begin
        start_nxt = 1'b1;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_idle) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_idle) begin
          if (i_req[owner] && burst < BURST_MAX) begin
            frame_nxt      = {1'b1, req_byte[owner], 1'b0};
            ack_nxt[owner] = 1'b1;
            burst_nxt      = burst + 4'd1;
            state_nxt      = S_START;
          end else begin
            last_nxt  = owner;
            grant_nxt = '0;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef UART_ARB_WDOG_EN
    wdog_nxt  = wdog;
    fault_nxt = fault;
    if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
      if (wdog == WDOG_LAST) begin
        fault_nxt = 1'b1;
        last_nxt  = owner;
        grant_nxt = '0;
        ack_nxt   = '0;
        frame_nxt = frame;
        burst_nxt = burst;
        state_nxt = S_IDLE;
        wdog_nxt  = '0;
      end else begin
        wdog_nxt = wdog + 1'b1;
      end
    end else begin
      wdog_nxt = '0;
    end
    if (state_nxt == S_START) wdog_nxt = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      last    <= LAST_RST;
      owner   <= '0;
      burst   <= '0;
      frame   <= 10'h3FF;
      o_ack   <= '0;
      o_grant <= '0;
      o_start <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      wdog    <= '0;
      fault   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      owner   <= owner_nxt;
      burst   <= burst_nxt;
      frame   <= frame_nxt;
      o_ack   <= ack_nxt;
      o_grant <= grant_nxt;
      o_start <= start_nxt;
`ifdef UART_ARB_WDOG_EN
      wdog    <= wdog_nxt;
      fault   <= fault_nxt;
`endif
    end
  end

  assign o_frame = frame;
  assign o_busy  = (state != S_IDLE);
  assign o_state = state;
`ifdef UART_ARB_WDOG_EN
  assign o_fault = fault;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: queue-based requesters, a bit-stepping transmitter
// model and a round-robin/burst reference that predicts the order of acknowledged bytes.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int MB   = 4;

  logic              clk = 1'b0;
  logic              i_reset;
  logic [NREQ-1:0]   i_req;
  logic [8*NREQ-1:0] i_data;
  logic [NREQ-1:0]   o_ack, o_grant;
  logic              o_start, o_busy, o_fault;
  logic [9:0]        o_frame;
  logic [3:0]        i_tx_bit;
  logic [2:0]        o_state;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MB), .TIMER_BITS(32), .CLOCKS_PER_BAUD(868)) dut (
    .clk(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data), .o_ack(o_ack),
    .o_grant(o_grant), .o_start(o_start), .o_frame(o_frame), .i_tx_bit(i_tx_bit),
    .o_busy(o_busy), .o_state(o_state), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  logic [7:0] rq [NREQ][$];
  int         exp_seq [$];
  int         model_last = NREQ - 1;
  int         ack_cnt = 0, gap_cnt = 0;
  int         bit_cyc = 2, tx_cnt = 0;
  bit         tx_active = 0, tx_stuck = 0;
  logic [9:0] tx_frame = '0, exp_frame = 10'h3FF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NREQ; k++) begin
      i_req[k]          = (rq[k].size() != 0);
      i_data[8*k +: 8]  = (rq[k].size() != 0) ? rq[k][0] : 8'h00;
    end
  endtask

  // Reference: each grant goes to the next non-empty requester after the last owner and
  // drains up to MB bytes from it.
  task automatic build_expected();
    int rem [NREQ];
    int c, n;
    bit found;
    for (int k = 0; k < NREQ; k++) rem[k] = rq[k].size();
    forever begin
      found = 0;
      c = 0;
      for (int i = 1; i <= NREQ; i++) begin
        if (!found && rem[(model_last + i) % NREQ] > 0) begin
          found = 1;
          c = (model_last + i) % NREQ;
        end
      end
      if (!found) break;
      n = (rem[c] < MB) ? rem[c] : MB;
      repeat (n) exp_seq.push_back(c);
      rem[c] -= n;
      model_last = c;
    end
  endtask

  task automatic tick();
    int k;
    logic [7:0] b;
    @(posedge clk);
    #1;
    if (tx_active) begin
      if (tx_cnt > 1) tx_cnt--;
      else if (i_tx_bit == 4'd9) begin
        chk("frame_stable", 32'(o_frame), 32'(tx_frame));
        tx_active = 0;
        i_tx_bit  = 4'hF;
      end else begin
        i_tx_bit = i_tx_bit + 4'd1;
        tx_cnt   = bit_cyc;
      end
    end
    if (o_start) begin
      chk("start_frame", 32'(o_frame), 32'(exp_frame));
      if (!tx_stuck) begin
        tx_active = 1;
        tx_frame  = o_frame;
        i_tx_bit  = 4'd0;
        tx_cnt    = bit_cyc;
      end
    end
    if (o_ack != '0) begin
      chk("ack_onehot", 32'($onehot(o_ack)), 32'd1);
      k = 0;
      for (int j = 0; j < NREQ; j++) if (o_ack[j]) k = j;
      if (exp_seq.size() == 0) chk("ack_unexpected", 32'(k), 32'hFF);
      else chk("ack_owner", 32'(k), 32'(exp_seq.pop_front()));
      chk("grant_owner", 32'(o_grant), 32'(1 << k));
      if (rq[k].size() != 0) begin
        b = rq[k].pop_front();
        exp_frame = {1'b1, b, 1'b0};
        chk("ack_frame", 32'(o_frame), 32'(exp_frame));
      end
      ack_cnt++;
    end
    chk("busy_state", 32'(o_busy), 32'(o_state != 3'd0));
    chk("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
    if (o_state == 3'd0 && ack_cnt > 0 && exp_seq.size() > 0) gap_cnt++;
    drive_inputs();
  endtask

  task automatic start_round();
    ack_cnt = 0;
    gap_cnt = 0;
    build_expected();
    drive_inputs();
  endtask

  task automatic run_round(input string tag);
    int n = 0;
    while (!(exp_seq.size() == 0 && o_state == 3'd0 && !tx_active) && n < 20000) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(exp_seq.size() == 0 && o_state == 3'd0 && !tx_active), 32'd1);
    for (int k = 0; k < NREQ; k++) chk({tag, "_drained"}, 32'(rq[k].size()), 32'd0);
  endtask

  task automatic reset_dut();
    i_reset = 1'b1;
    tick();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_ack",   32'(o_ack), 32'd0);
    chk("rst_start", 32'(o_start), 32'd0);
    chk("rst_frame", 32'(o_frame), 32'h3FF);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    i_reset = 1'b0;
    for (int k = 0; k < NREQ; k++) rq[k].delete();
    exp_seq.delete();
    tx_active  = 0;
    i_tx_bit   = 4'hF;
    model_last = NREQ - 1;
    exp_frame  = 10'h3FF;
    drive_inputs();
  endtask

  initial begin
    int n;
    i_reset  = 1'b1;
    i_req    = '0;
    i_data   = '0;
    i_tx_bit = 4'hF;
    tick();
    reset_dut();

    // first-byte latency and frame format
    rq[0].push_back(8'h41);
    start_round();
    tick();
    chk("lat_ack", 32'(o_ack), 32'h1);
    chk("lat_start_early", 32'(o_start), 32'd0);
    tick();
    chk("lat_start", 32'(o_start), 32'd1);
    chk("lat_frame", 32'(o_frame), 32'({1'b1, 8'h41, 1'b0}));
    run_round("lat");

    // lone requester longer than one burst: one IDLE cycle between bursts
    for (int i = 0; i < 6; i++) rq[2].push_back(8'($urandom));
    start_round();
    run_round("lone");
    chk("lone_acks", 32'(ack_cnt), 32'd6);
    chk("lone_gap", 32'(gap_cnt), 32'd1);

    // all requesters full from reset: 0,0,0,0,1,1,1,1,... twice round
    reset_dut();
    for (int k = 0; k < NREQ; k++)
      for (int i = 0; i < 8; i++) rq[k].push_back(8'($urandom));
    start_round();
    run_round("full");
    chk("full_acks", 32'(ack_cnt), 32'd32);

    for (int r = 0; r < 8; r++) begin
      bit_cyc = $urandom_range(1, 3);
      for (int k = 0; k < NREQ; k++) begin
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) rq[k].push_back(8'($urandom));
      end
      start_round();
      run_round("rand");
    end
    bit_cyc = 2;

    // reset while waiting for the transmitter to finish
    rq[0].push_back(8'h99);
    start_round();
    n = 0;
    while (o_state != 3'd3 && n < 200) begin
      tick();
      n++;
    end
    chk("mid_reached_wait_done", 32'(o_state), 32'd3);
    reset_dut();
    rq[1].push_back(8'h5C);
    start_round();
    run_round("after_rst");
    chk("after_rst_acks", 32'(ack_cnt), 32'd1);

`ifdef UART_ARB_WDOG_EN
    tx_stuck = 1;
    rq[0].push_back(8'h5A);
    start_round();
    n = 0;
    while (!o_fault && n < 12 * 868 + 200) begin
      tick();
      n++;
    end
    chk("wdog_fault", 32'(o_fault), 32'd1);
    chk("wdog_idle", 32'(o_state), 32'd0);
    chk("wdog_grant", 32'(o_grant), 32'd0);
    tx_stuck = 0;
    rq[0].push_back(8'hA5);
    start_round();
    run_round("wdog_after");
    chk("wdog_after_acks", 32'(ack_cnt), 32'd1);
    chk("wdog_sticky", 32'(o_fault), 32'd1);
`else
    chk("no_fault", 32'(o_fault), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
